mem_readout_reduce: RTL and testbench

Downstream reader for the 26-bit, 2048-entry distributed coefficient RAM in the SNTRUP757 multiplier datapath.
- On start, walks read addresses 0..deg of the RAM's asynchronous read port.
- Reduces each 26-bit accumulated coefficient modulo q=5167 through a 3-stage Barrett pipeline.
- Streams canonical 13-bit residues out on a valid/ready handshake to the next stage (packing/encode).

---
 rtl/mem_readout_reduce.sv | 135 +++++++++++++
 tb/tb_mem_readout_reduce.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_readout_reduce.sv
// Reads coefficients 0..deg from the accumulator RAM and streams each value
// reduced mod Q through a 3-stage Barrett pipeline on a valid/ready output.
module mem_readout_reduce #(
  parameter int Q         = 5167,
  parameter int IN_W      = 26,
  parameter int OUT_W     = 13,
  parameter int ADDR_W    = 11,
  parameter int BARRETT_M = 12987,
  parameter int BARRETT_K = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] deg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [IN_W-1:0]   rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int PROD_W = IN_W + 14;
  localparam int QH_W   = 14;
  localparam int R_W    = OUT_W + 1;
  localparam logic [R_W-1:0] Q_R = R_W'(Q);

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // while out_valid && !out_ready every stage and rd_addr hold their values.

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] deg_q, rd_addr_q;
  logic              s1_valid_q, s1_last_q;
  logic [IN_W-1:0]   s1_x_q;
  logic [ADDR_W-1:0] s1_idx_q;
  logic              s2_valid_q, s2_last_q;
  logic [IN_W-1:0]   s2_x_q;
  logic [QH_W-1:0]   s2_qhat_q;
  logic [ADDR_W-1:0] s2_idx_q;
  logic              out_valid_q, out_last_q;
  logic [OUT_W-1:0]  out_data_q;
  logic [ADDR_W-1:0] out_index_q;

  logic              advance, issue, at_last, last_hs;
  logic [QH_W-1:0]   qhat_d;
  logic [R_W-1:0]    r0, r1;
  logic [OUT_W-1:0]  red_d;

  assign advance = !out_valid_q || out_ready;
  assign issue   = (state_q == READ) && advance;
  assign at_last = (rd_addr_q == deg_q);
  assign last_hs = out_valid_q && out_ready && out_last_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (issue && at_last) state_d = DRAIN;
      DRAIN:   if (last_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // qhat never exceeds the true quotient, so x - qhat*Q lies in [0, 3Q).
  assign qhat_d = QH_W'((PROD_W'(s1_x_q) * PROD_W'(BARRETT_M)) >> BARRETT_K);

  always_comb begin
    r0    = R_W'((IN_W + 1)'(s2_x_q) - (IN_W + 1)'(s2_qhat_q) * (IN_W + 1)'(Q));
    r1    = (r0 >= Q_R) ? r0 - Q_R : r0;
    red_d = OUT_W'((r1 >= Q_R) ? r1 - Q_R : r1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deg_q       <= '0;
      rd_addr_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_x_q      <= '0;
      s1_idx_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_x_q      <= '0;
      s2_qhat_q   <= '0;
      s2_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        deg_q     <= deg;
        rd_addr_q <= '0;
      end else if (issue && !at_last) begin
        rd_addr_q <= rd_addr_q + 1'b1;
      end
      if (advance) begin
        s1_valid_q  <= issue;
        s1_x_q      <= rd_data;
        s1_idx_q    <= rd_addr_q;
        s1_last_q   <= at_last;
        s2_valid_q  <= s1_valid_q;
        s2_x_q      <= s1_x_q;
        s2_qhat_q   <= qhat_d;
        s2_idx_q    <= s1_idx_q;
        s2_last_q   <= s1_last_q;
        out_valid_q <= s2_valid_q;
        out_data_q  <= red_d;
        out_index_q <= s2_idx_q;
        out_last_q  <= s2_last_q;
      end
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_mem_readout_reduce.sv
// Directed bench for mem_readout_reduce: RAM model, beat scoreboard, stall and
// reset scenarios, single summary line.
module tb_mem_readout_reduce;

  localparam int Q  = 5167;
  localparam int BW = 25;  // {last, index[10:0], data[12:0]}

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [10:0] deg, rd_addr, out_index;
  logic [25:0] rd_data;
  logic        out_valid, out_last, busy, done;
  logic [12:0] out_data;

  logic [25:0] ram [0:2047];
  assign rd_data = ram[rd_addr];

  int vectors = 0;
  int miscompares = 0;
  int beats = 0;
  int rd_max = 0;
  logic [BW-1:0] exp_q[$];

  mem_readout_reduce dut (
    .clk(clk), .rst(rst), .start(start), .deg(deg), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // scoreboard / monitor
  logic          prev_stall = 1'b0;
  logic [12:0]   pd;
  logic [10:0]   pi;
  logic          pl;
  logic [BW-1:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (int'(rd_addr) > rd_max) rd_max = int'(rd_addr);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, pd);
        check("stall_index", out_index, pi);
        check("stall_last", out_last, pl);
      end
      if (out_valid && out_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_data", out_data, e[12:0]);
          check("beat_index", out_index, e[23:13]);
          check("beat_last", out_last, e[24]);
        end
        beats++;
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      pi = out_index;
      pl = out_last;
    end
  end

  // driver tasks
  task automatic push_exp(input int idx, input int data, input logic last);
    exp_q.push_back({last, 11'(idx), 13'(data)});
  endtask

  task automatic push_model(input int d);
    for (int i = 0; i <= d; i++) push_exp(i, int'(ram[i]) % Q, i == d);
  endtask

  task automatic fill_random(input int d);
    for (int i = 0; i <= d; i++) ram[i] = 26'($urandom());
  endtask

  task automatic do_start(input int d);
    @(posedge clk); #1;
    deg   = 11'(d);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic ready_pat(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (cyc < 10) return (cyc % 2) == 0;
    if (cyc < 15) return 1'b0;
    return 1'b1;
  endfunction

  // Called at cycle 0 of a run (#1 after the start edge); cyc = cycle of done.
  task automatic wait_done(input int mode, input int limit, output int cyc);
    logic got;
    got = 1'b0;
    cyc = 0;
    out_ready = ready_pat(mode, 0);
    while (!got && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
      out_ready = ready_pat(mode, cyc);
    end
    check("done_seen", got, 1);
    @(posedge clk); #1;
    check("done_single_pulse", done, 0);
    check("busy_clear", busy, 0);
    out_ready = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_index"}, out_index, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // directed sequence
  initial begin
    int cyc;
    int b0;
    rst = 1'b1; start = 1'b0; deg = '0; out_ready = 1'b1;
    for (int i = 0; i < 2048; i++) ram[i] = '0;
    #12;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Hand-computed residues: 5167->0, 5166->5166, 10334->0, 2^26-1->5034
    ram[0] = 26'd5167; ram[1] = 26'd5166; ram[2] = 26'd10334; ram[3] = 26'd67108863;
    push_exp(0, 0, 0); push_exp(1, 5166, 0); push_exp(2, 0, 0); push_exp(3, 5034, 1);
    do_start(3);
    check("t1_rd_addr0", rd_addr, 0);
    check("t1_busy", busy, 1);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c < 3) check("t1_no_valid_yet", out_valid, 0);
      if (c == 3) check("t1_first_valid", out_valid, 1);
      if (c == 6) check("t1_last_beat", out_last, 1);
      if (c == 7) check("t1_done", done, 1);
      if (c == 8) check("t1_done_clear", done, 0);
    end
    check("t1_drained", exp_q.size(), 0);

    // deg=0: 12345 mod 5167 = 2011
    ram[0] = 26'd12345;
    push_exp(0, 2011, 1);
    b0 = beats;
    do_start(0);
    wait_done(0, 20, cyc);
    check("t2_done_cycle", cyc, 4);
    check("t2_beats", beats - b0, 1);

    // deg=15 with toggling ready and a 5-cycle stall
    fill_random(15);
    push_model(15);
    b0 = beats;
    do_start(15);
    wait_done(1, 200, cyc);
    check("t3_beats", beats - b0, 16);
    check("t3_drained", exp_q.size(), 0);

    // deg=2047, full RAM with boundary values sprinkled in
    fill_random(2047);
    ram[5] = 26'd0; ram[6] = 26'd5166; ram[7] = 26'd15500; ram[2047] = 26'd67108863;
    push_model(2047);
    b0 = beats;
    do_start(2047);
    rd_max = 0;
    wait_done(0, 2200, cyc);
    check("t4_busy_window", cyc, 2051);
    check("t4_rd_addr_peak", rd_max, 2047);
    check("t4_beats", beats - b0, 2048);
    check("t4_drained", exp_q.size(), 0);

    // reset at beat 7 of a deg=20 run
    fill_random(20);
    push_model(20);
    b0 = beats;
    do_start(20);
    for (int c = 0; c < 60 && (beats - b0) < 7; c++) begin
      @(posedge clk); #1;
    end
    check("t5_reached_beat7", beats - b0, 7);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_idle_outputs("t5_async_reset");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("t5_no_done_in_reset", done, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("t5_idle_after_reset", busy, 0);
    check("t5_no_done_after_reset", done, 0);
    push_model(20);
    b0 = beats;
    do_start(20);
    wait_done(0, 200, cyc);
    check("t5_rerun_beats", beats - b0, 21);
    check("t5_rerun_drained", exp_q.size(), 0);

    // start while busy is ignored
    fill_random(10);
    push_model(10);
    b0 = beats;
    do_start(10);
    repeat (4) @(posedge clk);
    #1;
    deg = 11'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, 200, cyc);
    check("t6_beats", beats - b0, 11);
    check("t6_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
